cim_psum_acc_ctrl: RTL

Bit-plane accumulation controller for the digital CIM macro output path. It takes one signed 27-bit column partial sum per input bit plane, MSB plane first, and folds each into a 51-bit accumulator as acc = 2·acc ± psum. It uses the sign-extending CLA adder `se_cla` as its only arithmetic resource. It sits between the array's adder tree and the output buffer, with valid/ready handshakes on both sides.

---
 rtl/cim_acc_pkg.sv | 15 +
 rtl/cim_psum_acc_ctrl_se_cla.sv | 39 +++
 rtl/cim_psum_acc_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/cim_acc_pkg.sv
// Shared widths and FSM encoding for the CIM bit-plane accumulation path.
// PSUM_W/ACC_W are shared with the adder tree and the output buffer.
package cim_acc_pkg;

  localparam int PSUM_W = 27;
  localparam int ACC_W  = 51;
  localparam int PLN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/cim_psum_acc_ctrl_se_cla.sv
// Sign-extending carry-lookahead adder: sum_o = sext(a_i) + b_i, modulo 2^ACC_W.
// Carries are resolved per 3-bit group; ACC_W = 51 splits into 17 groups.
module se_cla
  import cim_acc_pkg::*;
(
  input  logic [PSUM_W-1:0] a_i,
  input  logic [ACC_W-1:0]  b_i,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int GW = 3;
  localparam int NG = ACC_W / GW;

  logic [ACC_W-1:0] x, g, p, c;
  logic [NG-1:0]    gc;

  always_comb begin
    logic gg, gp;
    x  = {{(ACC_W-PSUM_W){a_i[PSUM_W-1]}}, a_i};
    g  = x & b_i;
    p  = x ^ b_i;
    c  = '0;
    gc = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*GW] = gc[k];
      for (int j = 0; j < GW-1; j++) begin
        c[k*GW+j+1] = g[k*GW+j] | (p[k*GW+j] & c[k*GW+j]);
      end
      if (k < NG-1) begin
        gg = g[k*GW+2] | (p[k*GW+2] & g[k*GW+1])
           | (p[k*GW+2] & p[k*GW+1] & g[k*GW]);
        gp = p[k*GW+2] & p[k*GW+1] & p[k*GW];
        gc[k+1] = gg | (gp & gc[k]);
      end
    end
    sum_o = p ^ c;
  end

endmodule

// File: rtl/cim_psum_acc_ctrl.sv
// Bit-plane accumulation controller: acc = 2*acc +/- psum per plane, MSB plane first.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | accepting one partial sum per beat
//   DONE  | presenting out_acc until out_ready
module cim_psum_acc_ctrl
  import cim_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PLN_W-1:0]  nplanes_m1,
  input  logic              is_signed,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PLN_W-1:0]  cnt_q, cnt_d;
  logic [PLN_W-1:0]  nplanes_q, nplanes_d;
  logic              signed_q, signed_d;

  logic              start_ok, beat, last;
  logic [PSUM_W-1:0] add_a;
  logic [ACC_W-1:0]  add_b, add_sum;

  assign start_ok = start && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign beat     = (state_q == ACCUM) && in_valid;
  assign last     = (cnt_q == nplanes_q);

  // MSB plane of a signed job: acc is 0, so ~psum + 1 yields -sext(psum) on the same adder.
  always_comb begin
    if (signed_q && (cnt_q == '0)) begin
      add_a = ~in_psum;
      add_b = ACC_W'(1);
    end else begin
      add_a = in_psum;
      add_b = {acc_q[ACC_W-2:0], 1'b0};
    end
  end

  se_cla u_se_cla (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ACCUM;
      ACCUM:   if (beat && last) state_d = DONE;
      DONE:    if (out_ready) state_d = start_ok ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    nplanes_d = nplanes_q;
    signed_d  = signed_q;
    if (start_ok) begin
      acc_d     = '0;
      cnt_d     = '0;
      nplanes_d = nplanes_m1;
      signed_d  = is_signed;
    end else if (beat) begin
      acc_d = add_sum;
      if (!last) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      nplanes_q <= '0;
      signed_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      nplanes_q <= nplanes_d;
      signed_q  <= signed_d;
    end
  end

  assign out_acc = acc_q;

endmodule
